// File: rtl/popcount_accumulator.sv
// Chunked popcount of A, B and A&B over a VECTOR_WIDTH-bit fingerprint pair.
// Two-stage pipeline: masked per-chunk popcount, then accumulate and emit a valid pulse.
module popcount_accumulator #(
    parameter int VECTOR_WIDTH = 35,
    parameter int BUS_WIDTH    = 20,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_DataA,
    input  logic [BUS_WIDTH-1:0] i_DataB,
    input  logic                 i_Valid,
    input  logic                 i_Clear,
    output logic [CNT_WIDTH-1:0] o_CntA,
    output logic [CNT_WIDTH-1:0] o_CntB,
    output logic [CNT_WIDTH-1:0] o_CntC,
    output logic                 o_Valid,
    output logic [31:0]          o_PairCnt
);
    localparam int NUM_CHUNKS = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int LAST_BITS  = VECTOR_WIDTH - (NUM_CHUNKS - 1) * BUS_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int NCH        = 3;
    localparam logic [BUS_WIDTH-1:0] LAST_MASK = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - LAST_BITS);

    function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [BUS_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < BUS_WIDTH; i++) s = s + CNT_WIDTH'(v[i]);
        return s;
    endfunction

    // Channel 0 = A, 1 = B, 2 = A&B
    logic [IDX_W-1:0]                     r_idx;
    logic                                 w_accept, w_first, w_last;
    logic [BUS_WIDTH-1:0]                 w_mask;
    logic [NCH-1:0][BUS_WIDTH-1:0]        w_chunk;
    logic [NCH-1:0][CNT_WIDTH-1:0]        w_pcnt, w_sum;
    logic [NCH-1:0][CNT_WIDTH-1:0]        r_s1_cnt, r_acc, r_cnt;
    logic                                 r_s1_valid, r_s1_first, r_s1_last;
    logic                                 r_valid;
    logic [31:0]                          r_pair_cnt;

    assign w_accept   = i_Valid & ~i_Clear;
    assign w_first    = (r_idx == '0);
    assign w_last     = (r_idx == IDX_W'(NUM_CHUNKS - 1));
    assign w_mask     = w_last ? LAST_MASK : '1;
    assign w_chunk[0] = i_DataA & w_mask;
    assign w_chunk[1] = i_DataB & w_mask;
    assign w_chunk[2] = w_chunk[0] & w_chunk[1];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_pcnt[g] = popcnt(w_chunk[g]);
        assign w_sum[g]  = r_s1_first ? r_s1_cnt[g] : r_acc[g] + r_s1_cnt[g];
    end

    always_ff @(posedge clk) begin
        if (rst || i_Clear) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cnt   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_s1_cnt   <= w_pcnt;
            end
        end
    end

    // A clear in the emit cycle drops the stage-1 vector and its pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_pair_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_Clear) begin
                r_acc <= '0;
            end else if (r_s1_valid) begin
                r_acc <= w_sum;
                if (r_s1_last) begin
                    r_cnt      <= w_sum;
                    r_valid    <= 1'b1;
                    r_pair_cnt <= r_pair_cnt + 32'd1;
                end
            end
        end
    end

    assign o_CntA    = r_cnt[0];
    assign o_CntB    = r_cnt[1];
    assign o_CntC    = r_cnt[2];
    assign o_Valid   = r_valid;
    assign o_PairCnt = r_pair_cnt;
endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator at default parameters (35-bit vectors, 20-bit chunks).
module tb_popcount_accumulator;
    localparam int BW = 20;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] i_DataA, i_DataB;
    logic          i_Valid, i_Clear;
    logic [CW-1:0] o_CntA, o_CntB, o_CntC;
    logic          o_Valid;
    logic [31:0]   o_PairCnt;

    popcount_accumulator dut (
        .clk(clk), .rst(rst),
        .i_DataA(i_DataA), .i_DataB(i_DataB), .i_Valid(i_Valid), .i_Clear(i_Clear),
        .o_CntA(o_CntA), .o_CntB(o_CntB), .o_CntC(o_CntC),
        .o_Valid(o_Valid), .o_PairCnt(o_PairCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] a0, b0, a1, b1;
        int ea, eb, ec;
    } vec_t;

    typedef struct {
        int cyc;
        int a, b, c;
        int unsigned pair;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int unsigned exp_pair = 0;
    exp_t        q[$];
    vec_t        tbl[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (o_Valid) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("cntA", o_CntA, e.a);
                check("cntB", o_CntB, e.b);
                check("cntC", o_CntC, e.c);
                check("pair_cnt", o_PairCnt, e.pair);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic drive(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic v, input logic c);
        i_DataA = a;
        i_DataB = b;
        i_Valid = v;
        i_Clear = c;
    endtask

    // Pulse expected at the negedge two edges after the accepting edge
    task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit pulse,
                        input int ea, input int eb, input int ec);
        exp_t e;
        drive(a, b, 1'b1, 1'b0);
        if (pulse) begin
            exp_pair++;
            e = '{cyc + 2, ea, eb, ec, exp_pair};
            q.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        drive('0, '0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cntA"}, o_CntA, 0);
        check({tag, "_cntB"}, o_CntB, 0);
        check({tag, "_cntC"}, o_CntC, 0);
        check({tag, "_valid"}, o_Valid, 0);
        check({tag, "_pair"}, o_PairCnt, 0);
    endtask

    initial begin
        tbl[0] = '{20'hFFFFF, 20'h00000, 20'h07FFF, 20'h00000, 35, 0, 0};
        tbl[1] = '{20'h00000, 20'h00000, 20'hFFFFF, 20'hFFFFF, 15, 15, 15};
        tbl[2] = '{20'h00007, 20'h0000F, 20'h00000, 20'h00000, 3, 4, 3};
        tbl[3] = '{20'h0003F, 20'h00FC3, 20'h00000, 20'h00000, 6, 8, 2};
        tbl[4] = '{20'hFFFFF, 20'h00001, 20'h00000, 20'h00000, 20, 1, 1};
        tbl[5] = '{20'h00000, 20'hAAAAA, 20'hF8001, 20'hFFFFF, 1, 25, 1};
        tbl[6] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 35, 35, 35};

        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;

        // Table vectors back to back: one pulse every two cycles
        foreach (tbl[i]) begin
            send(tbl[i].a0, tbl[i].b0, 1'b0, 0, 0, 0);
            send(tbl[i].a1, tbl[i].b1, 1'b1, tbl[i].ea, tbl[i].eb, tbl[i].ec);
        end
        idle(3);
        check("pair_after_table", o_PairCnt, exp_pair);
        check("hold_cntA", o_CntA, 35);

        // Idle gap between chunks
        send(20'h0000F, 20'h000FF, 1'b0, 0, 0, 0);
        idle(3);
        send(20'h00001, 20'h00001, 1'b1, 5, 9, 5);
        idle(3);

        // Clear mid-vector
        send(20'hFFFFF, 20'h00000, 1'b0, 0, 0, 0);
        drive('0, '0, 1'b0, 1'b1);
        tick();
        send(20'h00003, 20'h00001, 1'b0, 0, 0, 0);
        send(20'h00000, 20'h00000, 1'b1, 2, 1, 1);
        idle(3);

        // Chunk presented with clear is discarded
        drive(20'hFFFFF, 20'hFFFFF, 1'b1, 1'b1);
        tick();
        send(20'h00001, 20'h00000, 1'b0, 0, 0, 0);
        send(20'h00002, 20'h00000, 1'b1, 2, 0, 0);
        idle(3);

        // Clear in the emit cycle suppresses the pulse; outputs hold
        send(20'hFFFFF, 20'hFFFFF, 1'b0, 0, 0, 0);
        send(20'h07FFF, 20'h07FFF, 1'b0, 0, 0, 0);
        drive('0, '0, 1'b0, 1'b1);
        tick();
        idle(4);
        check("pair_after_clear_suppress", o_PairCnt, exp_pair);
        check("hold_after_clear_cntA", o_CntA, 2);
        send(20'h00001, 20'h00001, 1'b0, 0, 0, 0);
        send(20'h00001, 20'h00001, 1'b1, 2, 2, 2);
        idle(3);

        // Reset in the emit cycle suppresses the pulse
        send(20'h00001, 20'h00001, 1'b0, 0, 0, 0);
        send(20'h00000, 20'h00000, 1'b0, 0, 0, 0);
        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        tick();
        check_zero("rst_emit");
        rst = 1'b0;
        exp_pair = 0;
        idle(3);

        // Reset mid-vector
        send(20'hFFFFF, 20'hFFFFF, 1'b0, 0, 0, 0);
        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        tick();
        check_zero("rst_mid");
        rst = 1'b0;
        exp_pair = 0;
        send(20'h00001, 20'h00003, 1'b0, 0, 0, 0);
        send(20'h00000, 20'h00001, 1'b1, 1, 3, 1);
        idle(4);
        check("pair_after_reset", o_PairCnt, 1);

        check("pending_pulses", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
